// File: rtl/batch_seal_ctrl.sv
// batch_seal_ctrl: fill/seal/execute/clear sequencer for the batch stage.
// Optional BATCH_SEAL_STATS_EN adds saturating batch and timeout-seal counters.
module batch_seal_ctrl #(
  parameter int MAX_BATCH_SIZE   = 48,
  parameter int BATCH_INDEX_BITS = 6,
  parameter int TIMEOUT_CYCLES   = 256,
  parameter int SEQ_BITS         = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_txn_accepted,
  input  logic                        i_flush_req,
  input  logic [BATCH_INDEX_BITS-1:0] i_cfg_max_size,
  input  logic                        i_exec_ready,
  input  logic                        i_exec_done,
  output logic                        o_batch_open,
  output logic                        o_seal_valid,
  output logic [BATCH_INDEX_BITS-1:0] o_seal_size,
  output logic [SEQ_BITS-1:0]         o_seal_id,
  output logic [1:0]                  o_seal_reason,
  output logic                        o_batch_clear,
  output logic                        o_overflow_err
`ifdef BATCH_SEAL_STATS_EN
  ,
  output logic [31:0]                 o_stat_batches,
  output logic [31:0]                 o_stat_timeouts
`endif
);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [BATCH_INDEX_BITS-1:0] MAX_W = BATCH_INDEX_BITS'(MAX_BATCH_SIZE);
  localparam logic [TW-1:0] TO_W = TW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = TIMEOUT_CYCLES != 0;
  typedef enum logic [2:0] {IDLE, FILLING, SEALED, EXEC, CLEAR} state_t;
  state_t                      r_state;
  logic [BATCH_INDEX_BITS-1:0] r_count;
  logic [BATCH_INDEX_BITS-1:0] r_seal_size;
  logic [TW-1:0]               r_timer;
  logic [SEQ_BITS-1:0]         r_seal_id;
  logic [1:0]                  r_seal_reason;
  logic                        r_seal_valid;
  logic                        r_clear;
  logic                        r_overflow;
  logic [BATCH_INDEX_BITS-1:0] w_eff_max;
  logic [BATCH_INDEX_BITS-1:0] w_count_next;
  logic [TW-1:0]               w_timer_next;
  logic                        w_accept;
  logic                        w_hit_size;
  logic                        w_hit_to;
  assign w_eff_max    = (i_cfg_max_size == '0 || i_cfg_max_size > MAX_W) ? MAX_W : i_cfg_max_size;
  assign o_batch_open = r_state == IDLE || (r_state == FILLING && r_count < w_eff_max);
  assign w_accept     = i_txn_accepted & o_batch_open;
  assign w_count_next = r_count + BATCH_INDEX_BITS'(w_accept);
  assign w_timer_next = (&r_timer) ? r_timer : r_timer + TW'(1);
  assign w_hit_size   = w_count_next >= w_eff_max;
  assign w_hit_to     = TO_EN && w_timer_next == TO_W;
  // Seal priority: size, then timeout, then flush; evaluated on next-cycle count/timer.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_timer       <= '0;
      r_seal_id     <= '0;
      r_seal_size   <= '0;
      r_seal_reason <= 2'b00;
      r_seal_valid  <= 1'b0;
      r_clear       <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_overflow <= i_txn_accepted & ~o_batch_open;
      r_clear    <= 1'b0;
      case (r_state)
        IDLE:
          if (i_txn_accepted) begin
            r_count <= BATCH_INDEX_BITS'(1);
            r_timer <= '0;
            r_state <= FILLING;
          end
        FILLING: begin
          r_count <= w_count_next;
          r_timer <= w_timer_next;
          if (w_hit_size || w_hit_to || i_flush_req) begin
            r_seal_size   <= w_count_next;
            r_seal_reason <= w_hit_size ? 2'b00 : w_hit_to ? 2'b01 : 2'b10;
            r_seal_valid  <= 1'b1;
            r_state       <= SEALED;
          end
        end
        SEALED:
          if (i_exec_ready) begin
            r_seal_valid <= 1'b0;
            r_state      <= EXEC;
          end
        EXEC:
          if (i_exec_done) begin
            r_clear <= 1'b1;
            r_state <= CLEAR;
          end
        CLEAR: begin
          r_count   <= '0;
          r_timer   <= '0;
          r_seal_id <= r_seal_id + SEQ_BITS'(1);
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign o_seal_valid   = r_seal_valid;
  assign o_seal_size    = r_seal_size;
  assign o_seal_id      = r_seal_id;
  assign o_seal_reason  = r_seal_reason;
  assign o_batch_clear  = r_clear;
  assign o_overflow_err = r_overflow;
`ifdef BATCH_SEAL_STATS_EN
  logic [31:0] r_stat_batches;
  logic [31:0] r_stat_timeouts;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_stat_batches  <= '0;
      r_stat_timeouts <= '0;
    end else begin
      if (r_state == EXEC && i_exec_done && ~&r_stat_batches)
        r_stat_batches <= r_stat_batches + 32'd1;
      if (r_state == FILLING && w_hit_to && !w_hit_size && ~&r_stat_timeouts)
        r_stat_timeouts <= r_stat_timeouts + 32'd1;
    end
  assign o_stat_batches  = r_stat_batches;
  assign o_stat_timeouts = r_stat_timeouts;
`endif
endmodule

// File: tb/tb_batch_seal_ctrl.sv
// tb_batch_seal_ctrl: directed stimulus with a behavioural reference model checked every cycle.
module tb_batch_seal_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txn = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] cfg = 6'd0;
  logic       ready = 1'b0;
  logic       done = 1'b0;
  logic       open_o, valid_o, clear_o, ovf_o;
  logic [5:0] size_o;
  logic [3:0] id_o;
  logic [1:0] reason_o;
  int n_chk = 0;
  int n_fail = 0;
`ifdef BATCH_SEAL_STATS_EN
  logic [31:0] stb_o, stt_o;
`endif
  batch_seal_ctrl #(.MAX_BATCH_SIZE(48), .BATCH_INDEX_BITS(6), .TIMEOUT_CYCLES(16), .SEQ_BITS(4)) dut (
    .clk(clk), .rst(rst), .i_txn_accepted(txn), .i_flush_req(flush), .i_cfg_max_size(cfg),
    .i_exec_ready(ready), .i_exec_done(done), .o_batch_open(open_o), .o_seal_valid(valid_o),
    .o_seal_size(size_o), .o_seal_id(id_o), .o_seal_reason(reason_o), .o_batch_clear(clear_o),
    .o_overflow_err(ovf_o)
`ifdef BATCH_SEAL_STATS_EN
    , .o_stat_batches(stb_o), .o_stat_timeouts(stt_o)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: phase 0 idle, 1 filling, 2 offered, 3 executing, 4 clearing.
  int m_ph, m_cnt, m_age, m_id, m_size, m_reason, m_nb, m_nto;
  bit m_valid, m_clear, m_ovf;
  function automatic int eff();
    int c = int'(cfg);
    return (c == 0 || c > 48) ? 48 : c;
  endfunction
  function automatic bit mopen();
    return m_ph == 0 || (m_ph == 1 && m_cnt < eff());
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_cnt = 0; m_age = 0; m_id = 0; m_size = 0; m_reason = 0;
      m_valid = 0; m_clear = 0; m_ovf = 0; m_nb = 0; m_nto = 0;
    end else begin : upd
      bit op;
      op = mopen();
      m_ovf = txn && !op;
      m_clear = 0;
      if (m_ph == 0) begin
        if (txn) begin m_ph = 1; m_cnt = 1; m_age = 0; end
      end else if (m_ph == 1) begin
        m_cnt = m_cnt + ((txn && op) ? 1 : 0);
        m_age = m_age + 1;
        if (m_cnt >= eff() || m_age == 16 || flush) begin
          m_reason = (m_cnt >= eff()) ? 0 : (m_age == 16) ? 1 : 2;
          if (m_reason == 1) m_nto++;
          m_size = m_cnt; m_valid = 1; m_ph = 2;
        end
      end else if (m_ph == 2) begin
        if (ready) begin m_valid = 0; m_ph = 3; end
      end else if (m_ph == 3) begin
        if (done) begin m_clear = 1; m_ph = 4; m_nb++; end
      end else begin
        m_cnt = 0; m_id = (m_id + 1) % 16; m_ph = 0;
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    chk("m_batch_open", 32'(open_o), 32'(mopen()));
    chk("m_seal_valid", 32'(valid_o), 32'(m_valid));
    chk("m_seal_size", 32'(size_o), m_size);
    chk("m_seal_id", 32'(id_o), m_id);
    chk("m_seal_reason", 32'(reason_o), m_reason);
    chk("m_batch_clear", 32'(clear_o), 32'(m_clear));
    chk("m_overflow_err", 32'(ovf_o), 32'(m_ovf));
`ifdef BATCH_SEAL_STATS_EN
    chk("m_stat_batches", stb_o, m_nb);
    chk("m_stat_timeouts", stt_o, m_nto);
`endif
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic pulse();
    txn = 1'b1;
    step();
    txn = 1'b0;
  endtask
  task automatic finish_batch();
    ready = 1'b1;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    step();
  endtask
  initial begin
    step();
    step();
    chk("rst_open", 32'(open_o), 1);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_id", 32'(id_o), 0);
    rst = 1'b0;
    // 1: size seal at 4 with exec_ready already high
    cfg = 6'd4; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      pulse();
    end
    chk("t1_valid", 32'(valid_o), 1);
    chk("t1_size", 32'(size_o), 4);
    chk("t1_reason", 32'(reason_o), 0);
    chk("t1_id", 32'(id_o), 0);
    chk("t1_open", 32'(open_o), 0);
    step();
    chk("t1_handshake", 32'(valid_o), 0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t1_clear", 32'(clear_o), 1);
    step();
    chk("t1_clear_end", 32'(clear_o), 0);
    chk("t1_id_next", 32'(id_o), 1);
    chk("t1_open_idle", 32'(open_o), 1);
    // 2: timeout seal exactly 16 edges after the first accept
    cfg = 6'd0; ready = 1'b0;
    pulse();
    repeat (15) step();
    chk("t2_not_yet", 32'(valid_o), 0);
    step();
    chk("t2_valid", 32'(valid_o), 1);
    chk("t2_size", 32'(size_o), 1);
    chk("t2_reason", 32'(reason_o), 1);
    finish_batch();
    chk("t2_id", 32'(id_o), 2);
    // 3/4: flush seal held without exec_ready, overflow while sealed
    ready = 1'b0;
    repeat (3) pulse();
    flush = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t3_valid", 32'(valid_o), 1);
      chk("t3_size", 32'(size_o), 3);
      chk("t3_reason", 32'(reason_o), 2);
      step();
    end
    pulse();
    chk("t4_ovf", 32'(ovf_o), 1);
    chk("t4_open", 32'(open_o), 0);
    chk("t4_size", 32'(size_o), 3);
    step();
    chk("t4_ovf_end", 32'(ovf_o), 0);
    ready = 1'b1;
    step();
    chk("t3_accepted", 32'(valid_o), 0);
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    step();
    step();
    chk("t3_flush_idle_open", 32'(open_o), 1);
    chk("t3_flush_idle_valid", 32'(valid_o), 0);
    chk("t3_id", 32'(id_o), 3);
    flush = 1'b0;
    // 5: reset during EXEC
    repeat (5) pulse();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_size", 32'(size_o), 5);
    step();
    chk("t5_exec", 32'(valid_o), 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_open", 32'(open_o), 1);
    chk("t5_id", 32'(id_o), 0);
    chk("t5_size_rst", 32'(size_o), 0);
    chk("t5_reason_rst", 32'(reason_o), 0);
    chk("t5_clear", 32'(clear_o), 0);
    step();
    rst = 1'b0;
    // 6: sequence number wrap over 17 single-txn batches
    cfg = 6'd1; ready = 1'b1;
    for (int b = 1; b <= 17; b++) begin
      pulse();
      if (b == 1) chk("t6_open_full", 32'(open_o), 0);
      step();
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      if (b >= 15) chk("t6_id", 32'(id_o), b % 16);
    end
`ifdef BATCH_SEAL_STATS_EN
    chk("t6_stat_batches", stb_o, 17);
`endif
    // 7: threshold lowered below count while filling
    cfg = 6'd0;
    repeat (5) pulse();
    cfg = 6'd3;
    #1;
    chk("t7_open_now", 32'(open_o), 0);
    step();
    chk("t7_valid", 32'(valid_o), 1);
    chk("t7_size", 32'(size_o), 5);
    chk("t7_reason", 32'(reason_o), 0);
    finish_batch();
    // 8: txn on the timeout edge, threshold above the hard cap
    cfg = 6'd50;
    pulse();
    repeat (15) step();
    pulse();
    chk("t8_valid", 32'(valid_o), 1);
    chk("t8_size", 32'(size_o), 2);
    chk("t8_reason", 32'(reason_o), 1);
    finish_batch();
    chk("t8_id", 32'(id_o), 3);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
